// File: rtl/fast_intr_ctrl_regs.sv
// fast_intr_ctrl_regs: register-bus slave latching fast interrupt lines into PENDING/ENABLE
// and raising one CPU interrupt. Optional macro: FAST_INTR_CTRL_LEVEL_EN (level-sensitive sources).
`default_nettype none

package fast_intr_ctrl_reg_pkg;
  typedef struct packed {
    logic [63:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module fast_intr_ctrl_regs
  import fast_intr_ctrl_reg_pkg::*;
#(
  parameter int unsigned NumIrq     = 16,
  parameter int unsigned SyncStages = 2,
  localparam int unsigned IdW       = (NumIrq > 1) ? $clog2(NumIrq) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  reg_req_t          reg_req_i,
  output reg_rsp_t          reg_rsp_o,
  input  logic [NumIrq-1:0] fast_irq_i,
  output logic              irq_o,
  output logic [IdW-1:0]    irq_id_o
);

  localparam logic [11:0] OffPending = 12'h000;
  localparam logic [11:0] OffEnable  = 12'h004;
  localparam logic [11:0] OffClear   = 12'h008;
  localparam logic [11:0] OffSet     = 12'h00C;
  localparam logic [11:0] OffStatus  = 12'h010;

  typedef enum logic {IDLE, RESP} state_e;

  state_e                          state_q, state_d;
  logic [31:0]                     rdata_q, rdata_d;
  logic                            err_q, err_d;
  logic [NumIrq-1:0]               en_q, en_d;
  logic [NumIrq-1:0]               pend_q, pend_d;
  logic                            irq_q, irq_d;
  logic [IdW-1:0]                  id_q, id_d;
  logic [SyncStages-1:0][NumIrq-1:0] sync_q;

  logic [NumIrq-1:0] synced, hw_set, sw_set, sw_clr, active;
  logic [11:0]       offset;
  logic [31:0]       wmask, wval, rd_word;
  logic              req_bad;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= fast_irq_i;
      for (int s = 1; s < SyncStages; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign synced = sync_q[SyncStages-1];

`ifdef FAST_INTR_CTRL_LEVEL_EN
  assign hw_set = synced;
`else
  logic [NumIrq-1:0] prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) prev_q <= '0;
    else       prev_q <= synced;
  end

  assign hw_set = synced & ~prev_q;
`endif

  assign offset = reg_req_i.addr[11:0];

  always_comb begin
    for (int b = 0; b < 4; b++) wmask[8*b +: 8] = {8{reg_req_i.wstrb[b]}};
  end

  assign wval    = reg_req_i.wdata & wmask;
  assign req_bad = (offset[1:0] != 2'b00) || (offset > OffStatus) ||
                   (reg_req_i.write && (offset == OffPending || offset == OffStatus));

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    en_d    = en_q;
    sw_set  = '0;
    sw_clr  = '0;
    rd_word = '0;
    case (state_q)
      IDLE: begin
        if (reg_req_i.valid) begin
          state_d = RESP;
          err_d   = req_bad;
          if (!req_bad) begin
            if (reg_req_i.write) begin
              case (offset)
                OffEnable: en_d   = (en_q & ~wmask[NumIrq-1:0]) | wval[NumIrq-1:0];
                OffClear:  sw_clr = wval[NumIrq-1:0];
                OffSet:    sw_set = wval[NumIrq-1:0];
                default: ;
              endcase
            end else begin
              case (offset)
                OffPending: rd_word[NumIrq-1:0] = pend_q;
                OffEnable:  rd_word[NumIrq-1:0] = en_q;
                OffStatus:  rd_word[NumIrq-1:0] = pend_q & en_q;
                default: ;
              endcase
            end
          end
          rdata_d = rd_word;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Hardware set is ORed in last so a coincident CLEAR never drops a fresh edge.
  assign pend_d = ((pend_q | sw_set) & ~sw_clr) | hw_set;
  assign active = pend_q & en_q;
  assign irq_d  = |active;

  always_comb begin
    id_d = '0;
    for (int i = NumIrq - 1; i >= 0; i--) begin
      if (active[i]) id_d = IdW'(i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
      en_q    <= '0;
      pend_q  <= '0;
      irq_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
      irq_q   <= irq_d;
      id_q    <= id_d;
    end
  end

  assign reg_rsp_o = {rdata_q, err_q, (state_q == RESP)};
  assign irq_o     = irq_q;
  assign irq_id_o  = id_q;

  logic unused_bits;
  assign unused_bits = ^{reg_req_i.addr[63:12], wval, wmask};

endmodule

`default_nettype wire

// File: tb/tb_fast_intr_ctrl_regs.sv
// Directed self-checking bench for fast_intr_ctrl_regs (NumIrq=16, SyncStages=2).
`default_nettype none

module tb_fast_intr_ctrl_regs;
  import fast_intr_ctrl_reg_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  reg_req_t    req;
  reg_rsp_t    rsp;
  logic [15:0] fast_irq;
  logic        irq;
  logic [3:0]  irq_id;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  fast_intr_ctrl_regs #(.NumIrq(16), .SyncStages(2)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .reg_req_i  (req),
    .reg_rsp_o  (rsp),
    .fast_irq_i (fast_irq),
    .irq_o      (irq),
    .irq_id_o   (irq_id)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, output logic [31:0] rd, output logic err,
                        output int lat);
    @(negedge clk);
    req.addr  = {52'h0, addr};
    req.write = wr;
    req.wdata = wd;
    req.wstrb = strb;
    req.valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!rsp.ready && lat < 10);
    rd  = rsp.rdata;
    err = rsp.error;
    @(negedge clk);
    req.valid = 1'b0;
    req.write = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        err;
    int          lat;
    access(1'b0, addr, 32'h0, 4'h0, rd, err, lat);
    check({tag, "_lat"}, lat, 1);
    check({tag, "_err"}, {31'h0, err}, 0);
    check({tag, "_data"}, rd, exp);
  endtask

  task automatic wr_chk(input string tag, input logic [11:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, input logic exp_err);
    logic [31:0] rd;
    logic        err;
    int          lat;
    access(1'b1, addr, wd, strb, rd, err, lat);
    check({tag, "_lat"}, lat, 1);
    check({tag, "_err"}, {31'h0, err}, {31'h0, exp_err});
  endtask

  task automatic rd_err(input string tag, input logic [11:0] addr);
    logic [31:0] rd;
    logic        err;
    int          lat;
    access(1'b0, addr, 32'h0, 4'h0, rd, err, lat);
    check({tag, "_lat"}, lat, 1);
    check({tag, "_err"}, {31'h0, err}, 1);
  endtask

  initial begin
    req      = '0;
    fast_irq = '0;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_irq", {31'h0, irq}, 0);
    check("rst_id", {28'h0, irq_id}, 0);
    check("rst_ready", {31'h0, rsp.ready}, 0);
    check("rst_rdata", rsp.rdata, 0);
    @(negedge clk);
    rst = 1'b0;

    rd_chk("rd_pending0", 12'h000, 32'h0);
    rd_chk("rd_enable0", 12'h004, 32'h0);
    rd_chk("rd_status0", 12'h010, 32'h0);

    wr_chk("wr_en5", 12'h004, 32'h0000_0005, 4'h1, 1'b0);
    rd_chk("rd_en5", 12'h004, 32'h5);

    // Line 2 rises before edge k; irq must appear exactly at edge k+3.
    @(negedge clk);
    fast_irq[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("irq_early", {31'h0, irq}, 0);
    @(negedge clk);
    fast_irq[2] = 1'b0;
    @(posedge clk);
    #1;
    check("irq_k3", {31'h0, irq}, 1);
    check("id_k3", {28'h0, irq_id}, 2);
    rd_chk("rd_pend4", 12'h000, 32'h4);
    rd_chk("rd_stat4", 12'h010, 32'h4);

    wr_chk("clr4", 12'h008, 32'h4, 4'hF, 1'b0);
    check("irq_before_drop", {31'h0, irq}, 1);
    @(posedge clk);
    #1;
    check("irq_dropped", {31'h0, irq}, 0);
    check("id_dropped", {28'h0, irq_id}, 0);

    wr_chk("wr_enffff", 12'h004, 32'h0000_FFFF, 4'h3, 1'b0);
    @(negedge clk);
    fast_irq[9] = 1'b1;
    fast_irq[3] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("irq_93", {31'h0, irq}, 1);
    check("id_93", {28'h0, irq_id}, 3);
    @(negedge clk);
    fast_irq = '0;
    rd_chk("rd_pend208", 12'h000, 32'h208);
    wr_chk("clr3", 12'h008, 32'h8, 4'hF, 1'b0);
    @(posedge clk);
    #1;
    check("id_9", {28'h0, irq_id}, 9);
    wr_chk("clr9", 12'h008, 32'h200, 4'hF, 1'b0);

    // CLEAR accepted on the very edge that line 0 sets PENDING (edge k+2).
    @(negedge clk);
    fast_irq[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    wr_chk("race_clr", 12'h008, 32'h1, 4'hF, 1'b0);
    rd_chk("race_pend", 12'h000, 32'h1);
    @(negedge clk);
    fast_irq[0] = 1'b0;
    repeat (3) @(posedge clk);
    wr_chk("clr0", 12'h008, 32'h1, 4'hF, 1'b0);
    rd_chk("rd_pend0b", 12'h000, 32'h0);

    wr_chk("wr_pend_err", 12'h000, 32'hFFFF, 4'hF, 1'b1);
    rd_chk("pend_after_err", 12'h000, 32'h0);
    rd_err("rd_014", 12'h014);
    wr_chk("wr_006", 12'h006, 32'h0, 4'hF, 1'b1);
    rd_err("rd_006", 12'h006);
    rd_chk("en_after_err", 12'h004, 32'h0000_FFFF);
    wr_chk("wr_stat_err", 12'h010, 32'hFFFF, 4'hF, 1'b1);
    wr_chk("wr_enall", 12'h004, 32'hFFFF_FFFF, 4'hF, 1'b0);
    rd_chk("rd_enall", 12'h004, 32'h0000_FFFF);

    wr_chk("set10", 12'h00C, 32'h10, 4'hF, 1'b0);
    rd_chk("rd_pend10", 12'h000, 32'h10);
    rd_chk("rd_clr0", 12'h008, 32'h0);
    rd_chk("rd_set0", 12'h00C, 32'h0);
    check("id_4", {28'h0, irq_id}, 4);
    check("irq_set", {31'h0, irq}, 1);
    wr_chk("en_byte1", 12'h004, 32'h0, 4'h2, 1'b0);
    rd_chk("rd_en00ff", 12'h004, 32'h0000_00FF);
    rd_chk("rd_stat10", 12'h010, 32'h10);

    // Reset while a response is pending aborts it.
    @(negedge clk);
    req.addr  = 64'h4;
    req.write = 1'b0;
    req.valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_ready", {31'h0, rsp.ready}, 0);
    check("abort_irq", {31'h0, irq}, 0);
    req.valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rd_chk("rd_en_rst", 12'h004, 32'h0);
    rd_chk("rd_pend_rst", 12'h000, 32'h0);

`ifdef FAST_INTR_CTRL_LEVEL_EN
    wr_chk("lv_en", 12'h004, 32'h2, 4'hF, 1'b0);
    @(negedge clk);
    fast_irq[1] = 1'b1;
    repeat (4) @(posedge clk);
    wr_chk("lv_clr_held", 12'h008, 32'h2, 4'hF, 1'b0);
    rd_chk("lv_pend_held", 12'h000, 32'h2);
    @(negedge clk);
    fast_irq[1] = 1'b0;
    repeat (4) @(posedge clk);
    wr_chk("lv_clr_rel", 12'h008, 32'h2, 4'hF, 1'b0);
    rd_chk("lv_pend_rel", 12'h000, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
